// File: rtl/wb_mem_slave_model_pkg.sv
// wb_model_pkg: types and constants shared by the Wishbone memory slave model.
//   state_t    - FSM state encoding (IDLE / WAIT / RESP), 2 bits
//   TERM_*     - termination codes (none / ack / err / rty)
//   lane_shift - log2 of the number of byte lanes in a DW-bit word
package wb_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] TERM_NONE = 2'd0;
  localparam logic [1:0] TERM_ACK  = 2'd1;
  localparam logic [1:0] TERM_ERR  = 2'd2;
  localparam logic [1:0] TERM_RTY  = 2'd3;

  // Byte-address bits below word alignment for a dw-bit data bus.
  function automatic int unsigned lane_shift(input int unsigned dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/wb_mem_slave_model_if.sv
// wb_mem_slave_model_if: Wishbone classic bus bundle.
//   master modport drives adr/dat_i/sel/we/cyc/stb and receives dat_o/ack/err/rty;
//   slave modport is the mirror image.
// Signal names follow the slave's point of view (_i into the slave, _o out of it).
interface wb_mem_slave_model_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic [AW-1:0]   wb_adr_i;
  logic [DW-1:0]   wb_dat_i;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_mem_slave_model_ram.sv
// wb_mem_bytelane_ram: DEPTH x DW storage with per-byte-lane write enables and a
// per-word valid bit.
// Ports:
//   clk, rst_n - clock; asynchronous active-low reset (clears valid bits only)
//   wr_en      - commit a write to word idx this cycle
//   idx        - word index for both the write and the combinational read
//   wr_sel     - byte lanes to update
//   wr_dat     - write data
//   rd_dat     - stored word at idx
//   rd_vld     - word at idx has been written since reset
module wb_mem_bytelane_ram #(
  parameter int unsigned   DW        = 32,
  parameter int unsigned   DEPTH     = 16,
  parameter int unsigned   IW        = 4,
  parameter logic [DW-1:0] INIT_FILL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [IW-1:0]   idx,
  input  logic [DW/8-1:0] wr_sel,
  input  logic [DW-1:0]   wr_dat,
  output logic [DW-1:0]   rd_dat,
  output logic            rd_vld
);
  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] vld;

  // A partial write to a never-written word fills the unselected lanes with
  // the init pattern, so later reads see init bytes rather than stale data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < int'(DW / 8); l++) begin
        if (wr_sel[l])
          mem[idx][8*l +: 8] <= wr_dat[8*l +: 8];
        else if (!vld[idx])
          mem[idx][8*l +: 8] <= INIT_FILL[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld <= '0;
    else if (wr_en && (|wr_sel))
      vld[idx] <= 1'b1;
  end

  assign rd_dat = mem[idx];
  assign rd_vld = vld[idx];
endmodule

// File: rtl/wb_mem_slave_model.sv
// wb_mem_slave_model: Wishbone classic slave backed by a DEPTH-word byte-lane
// memory, with programmable wait states and error response for unmapped addresses.
// Ports:
//   wb_clk_i      - bus clock
//   wb_rst_i      - asynchronous active-low reset
//   bus           - Wishbone slave modport (adr, dat_i/dat_o, sel, we, cyc, stb,
//                   ack, err, rty)
//   wait_cycles_i - wait states before termination, sampled when a request is taken
//   acc_count_o   - number of ack-terminated accesses (wraps)
//   last_adr_o    - byte address of the most recent terminated access
// Optional build macro WB_SLAVE_RTY_INJECT_EN: every RTY_PERIOD-th in-range
// access is terminated with retry instead of ack.
module wb_mem_slave_model
  import wb_model_pkg::*;
#(
  parameter int unsigned   DW         = 32,
  parameter int unsigned   AW         = 32,
  parameter int unsigned   DEPTH      = 16,
  parameter logic [AW-1:0] BASE_ADR   = '0,
  parameter logic [31:0]   INIT_WORD  = 32'hA5A5A5A5,
  parameter int unsigned   RTY_PERIOD = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_mem_slave_model_if.slave  bus,
  input  logic [3:0]           wait_cycles_i,
  output logic [15:0]          acc_count_o,
  output logic [AW-1:0]        last_adr_o
);
  localparam int unsigned NL  = DW / 8;
  localparam int unsigned LSB = lane_shift(DW);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // INIT_WORD replicated byte-wise across the DW-bit word.
  function automatic logic [DW-1:0] init_fill();
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < int'(NL); k++)
      w[8*k +: 8] = INIT_WORD[8*(k%4) +: 8];
    return w;
  endfunction

  localparam logic [DW-1:0] INIT_FILL = init_fill();

  state_t        state;
  logic [3:0]    wcnt;
  logic          ok_q, ack_q, err_q, rty_q;
  logic [15:0]   acc_q;
  logic [AW-1:0] last_q;

  logic [AW-1:0] adr_q;
  logic          we_q;
  logic [NL-1:0] sel_q;
  logic [DW-1:0] dat_q;
  logic [IW-1:0] idx_q;

  logic          req, accept, enter_resp, ok_now, rty_hit, commit, wr_en, in_range;
  logic [AW-1:0] off, word_off;
  logic [DW-1:0] rd_dat;
  logic          rd_vld;

  assign req      = bus.wb_cyc_i & bus.wb_stb_i;
  assign off      = bus.wb_adr_i - BASE_ADR;
  assign word_off = off >> LSB;
  assign in_range = (bus.wb_adr_i >= BASE_ADR) && (word_off < AW'(DEPTH));
  assign accept   = (state == IDLE) && req && !(ack_q | err_q | rty_q);
  assign ok_now   = (state == IDLE) ? in_range : ok_q;

  // Termination flags are registered on the edge that enters RESP, so they are
  // high exactly during the RESP cycle.
  assign enter_resp = (accept && (wait_cycles_i == 4'd0)) ||
                      ((state == WAIT) && req && (wcnt == 4'd1));

  // Side effects happen at the end of RESP and only if the master still holds
  // the cycle; a drop during RESP leaves memory and counters untouched.
  assign commit = (state == RESP) && req;
  assign wr_en  = commit && ack_q && we_q;

`ifdef WB_SLAVE_RTY_INJECT_EN
  localparam int unsigned RW = (RTY_PERIOD > 1) ? $clog2(RTY_PERIOD) : 1;
  logic [RW-1:0] rty_cnt;

  assign rty_hit = enter_resp && ok_now && (rty_cnt == RW'(RTY_PERIOD - 1));

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)
      rty_cnt <= '0;
    else if (enter_resp && ok_now)
      rty_cnt <= rty_hit ? '0 : rty_cnt + RW'(1);
  end
`else
  // Always 0; the comparison only keeps RTY_PERIOD referenced in this build.
  assign rty_hit = (RTY_PERIOD == 0) && 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state  <= IDLE;
      wcnt   <= 4'd0;
      ok_q   <= 1'b0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      rty_q  <= 1'b0;
      acc_q  <= 16'd0;
      last_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      if (enter_resp) begin
        ack_q <= ok_now && !rty_hit;
        err_q <= !ok_now;
        rty_q <= rty_hit;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            ok_q  <= in_range;
            wcnt  <= wait_cycles_i;
            state <= (wait_cycles_i == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!req)
            state <= IDLE;
          else if (wcnt == 4'd1)
            state <= RESP;
          else
            wcnt <= wcnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          if (req) begin
            last_q <= adr_q;
            if (ack_q)
              acc_q <= acc_q + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture: data path only, no reset needed.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      adr_q <= bus.wb_adr_i;
      we_q  <= bus.wb_we_i;
      sel_q <= bus.wb_sel_i;
      dat_q <= bus.wb_dat_i;
      idx_q <= word_off[IW-1:0];
    end
  end

  wb_mem_bytelane_ram #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .IW        (IW),
    .INIT_FILL (INIT_FILL)
  ) u_ram (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_i),
    .wr_en  (wr_en),
    .idx    (idx_q),
    .wr_sel (sel_q),
    .wr_dat (dat_q),
    .rd_dat (rd_dat),
    .rd_vld (rd_vld)
  );

  // Read data is driven only during a read ack; sel does not mask reads.
  assign bus.wb_dat_o = (ack_q && !we_q) ? (rd_vld ? rd_dat : INIT_FILL) : '0;
  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;
  assign bus.wb_rty_o = rty_q;
  assign acc_count_o  = acc_q;
  assign last_adr_o   = last_q;
endmodule

// File: tb/tb_wb_mem_slave_model.sv
// Testbench for wb_mem_slave_model (DW 32, DEPTH 16, BASE 0, INIT A5A5A5A5).
// Table of single accesses with expected termination, latency and read data,
// followed by hand-written sequences: wait change mid-access, abort, reset in WAIT.
// With WB_SLAVE_RTY_INJECT_EN defined, runs the retry-injection sequence instead.
module tb_wb_mem_slave_model;
  import wb_model_pkg::*;

  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_ACK  = 3'b100;
  localparam logic [2:0] T_ERR  = 3'b010;
  localparam logic [2:0] T_RTY  = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  wait_cycles;
  logic [15:0] acc_count;
  logic [31:0] last_adr;
  int          n_cmp = 0;
  int          n_err = 0;

  wb_mem_slave_model_if #(.DW(32), .AW(32)) bus ();

  wb_mem_slave_model #(
    .DW(32), .AW(32), .DEPTH(16), .BASE_ADR(32'h0),
    .INIT_WORD(32'hA5A5A5A5), .RTY_PERIOD(4)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst_n),
    .bus           (bus),
    .wait_cycles_i (wait_cycles),
    .acc_count_o   (acc_count),
    .last_adr_o    (last_adr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [3:0]  wt;
    logic [2:0]  term;
    int          lat;
    logic [31:0] rdat;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One access: drive after an edge, sample #1 after each following edge,
  // hold the request through the termination cycle, then release.
  task automatic txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                     input logic [31:0] dat, input logic [3:0] wt,
                     input int chg_at, input logic [3:0] chg_val,
                     output logic [2:0] term, output int lat, output logic [31:0] rdat);
    @(posedge clk); #1;
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    wait_cycles  = wt;
    term = T_NONE;
    lat  = 0;
    rdat = '0;
    while (term == T_NONE && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      term = {bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o};
      rdat = bus.wb_dat_o;
      if (lat == chg_at) wait_cycles = chg_val;
    end
    @(posedge clk); #1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  initial begin
    logic [2:0]  term;
    int          lat;
    logic [31:0] rdat;
    int          exp_acc;

    tbl[0]  = '{32'h08, 1'b1, 4'hF, 32'h12345678, 4'd0, T_ACK, 1, 32'h0};
    tbl[1]  = '{32'h08, 1'b0, 4'hF, 32'h0,        4'd0, T_ACK, 1, 32'h12345678};
    tbl[2]  = '{32'h04, 1'b0, 4'hF, 32'h0,        4'd0, T_ACK, 1, 32'hA5A5A5A5};
    tbl[3]  = '{32'h04, 1'b1, 4'h3, 32'hDEADBEEF, 4'd0, T_ACK, 1, 32'h0};
    tbl[4]  = '{32'h04, 1'b0, 4'h0, 32'h0,        4'd0, T_ACK, 1, 32'hA5A5BEEF};
    tbl[5]  = '{32'h00, 1'b0, 4'hF, 32'h0,        4'd5, T_ACK, 6, 32'hA5A5A5A5};
    tbl[6]  = '{32'h40, 1'b0, 4'hF, 32'h0,        4'd0, T_ERR, 1, 32'h0};
    tbl[7]  = '{32'h3C, 1'b1, 4'hF, 32'hCAFEF00D, 4'd2, T_ACK, 3, 32'h0};
    tbl[8]  = '{32'h3F, 1'b0, 4'hF, 32'h0,        4'd0, T_ACK, 1, 32'hCAFEF00D};
    tbl[9]  = '{32'h0A, 1'b1, 4'hC, 32'h11223344, 4'd1, T_ACK, 2, 32'h0};
    tbl[10] = '{32'h08, 1'b0, 4'hF, 32'h0,        4'd0, T_ACK, 1, 32'h11225678};
    tbl[11] = '{32'h44, 1'b1, 4'hF, 32'h0,        4'd1, T_ERR, 2, 32'h0};

    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    wait_cycles = 4'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_term", 64'({bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o}), 64'(T_NONE));
    chk("rst_dat",  64'(bus.wb_dat_o), 64'h0);
    chk("rst_acc",  64'(acc_count), 64'h0);
    chk("rst_last", 64'(last_adr), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef WB_SLAVE_RTY_INJECT_EN
    for (int i = 0; i < 4; i++) begin
      txn(32'h08, 1'b0, 4'hF, 32'h0, 4'd0, 0, 4'd0, term, lat, rdat);
      chk("rty_term", 64'(term), 64'((i == 3) ? T_RTY : T_ACK));
      chk("rty_lat",  64'(lat), 64'd1);
      chk("rty_rdat", 64'(rdat), (i == 3) ? 64'h0 : 64'hA5A5A5A5);
      chk("rty_acc",  64'(acc_count), 64'((i < 3) ? i + 1 : 3));
      chk("rty_last", 64'(last_adr), 64'h08);
    end
`else
    exp_acc = 0;
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].dat, tbl[i].wt, 0, 4'd0, term, lat, rdat);
      if (tbl[i].term == T_ACK) exp_acc++;
      chk($sformatf("v%0d_term", i), 64'(term), 64'(tbl[i].term));
      chk($sformatf("v%0d_lat", i),  64'(lat), 64'(tbl[i].lat));
      chk($sformatf("v%0d_rdat", i), 64'(rdat), 64'(tbl[i].rdat));
      chk($sformatf("v%0d_1cyc", i), 64'({bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o}), 64'(T_NONE));
      chk($sformatf("v%0d_acc", i),  64'(acc_count), 64'(exp_acc));
      chk($sformatf("v%0d_last", i), 64'(last_adr), 64'(tbl[i].adr));
    end

    // wait_cycles changed after the request is taken must not alter latency
    txn(32'h08, 1'b0, 4'hF, 32'h0, 4'd5, 2, 4'd0, term, lat, rdat);
    exp_acc++;
    chk("chg_term", 64'(term), 64'(T_ACK));
    chk("chg_lat",  64'(lat), 64'd6);
    chk("chg_rdat", 64'(rdat), 64'h11225678);
    chk("chg_acc",  64'(acc_count), 64'(exp_acc));

    // abort: write with 3 wait states, cycle dropped after 2 cycles
    @(posedge clk); #1;
    bus.wb_adr_i = 32'h08; bus.wb_we_i = 1'b1; bus.wb_sel_i = 4'hF;
    bus.wb_dat_i = 32'hFFFFFFFF; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    wait_cycles = 4'd3;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("abort_wait", 64'({bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o}), 64'(T_NONE));
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("abort_quiet", 64'({bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o}), 64'(T_NONE));
    end
    chk("abort_acc",  64'(acc_count), 64'(exp_acc));
    chk("abort_last", 64'(last_adr), 64'h08);
    txn(32'h08, 1'b0, 4'hF, 32'h0, 4'd0, 0, 4'd0, term, lat, rdat);
    exp_acc++;
    chk("abort_term", 64'(term), 64'(T_ACK));
    chk("abort_mem",  64'(rdat), 64'h11225678);

    // reset while in WAIT: outputs clear at once, valid bits forgotten
    @(posedge clk); #1;
    bus.wb_adr_i = 32'h08; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    wait_cycles = 4'd8;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_term", 64'({bus.wb_ack_o, bus.wb_err_o, bus.wb_rty_o}), 64'(T_NONE));
    chk("rstw_dat",  64'(bus.wb_dat_o), 64'h0);
    chk("rstw_acc",  64'(acc_count), 64'h0);
    chk("rstw_last", 64'(last_adr), 64'h0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(32'h08, 1'b0, 4'hF, 32'h0, 4'd0, 0, 4'd0, term, lat, rdat);
    chk("rstw_rd8_term", 64'(term), 64'(T_ACK));
    chk("rstw_rd8",      64'(rdat), 64'hA5A5A5A5);
    txn(32'h3C, 1'b0, 4'hF, 32'h0, 4'd0, 0, 4'd0, term, lat, rdat);
    chk("rstw_rd3c",     64'(rdat), 64'hA5A5A5A5);
    chk("rstw_acc2",     64'(acc_count), 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
